// File: rtl/pcs_sync_pkg.sv
// Shared types, code-group constants and classification helpers for the
// multi-lane PCS code-group synchronizer.
package pcs_sync_pkg;

  typedef enum logic [1:0] {
    StLossOfSync,
    StCommaDetect,
    StAcquireSync,
    StSyncAcquired
  } sync_state_e;

  localparam logic [6:0] COMMA_P = 7'b0011111;
  localparam logic [6:0] COMMA_N = 7'b1100000;

  localparam logic [9:0] COMMA = 10'b1100000101;
  localparam logic [9:0] D1    = 10'b0110001011;
  localparam logic [9:0] D2    = 10'b1000101011;
  localparam logic [9:0] D3    = 10'b0100101011;
  localparam logic [9:0] D4    = 10'b1001000101;
  localparam logic [9:0] BAD   = 10'b0000000000;

  function automatic logic is_comma(input logic [9:0] cg);
    return (cg[9:3] == COMMA_P) || (cg[9:3] == COMMA_N);
  endfunction

  // Running-disparity-legal code groups carry 4, 5 or 6 ones.
  function automatic logic is_invalid(input logic [9:0] cg);
    logic [3:0] ones;
    ones = '0;
    for (int i = 0; i < 10; i++) begin
      ones = ones + {3'b000, cg[i]};
    end
    return (ones < 4'd4) || (ones > 4'd6);
  endfunction

endpackage

// File: rtl/pcs_sync_lane.sv
// Single-lane code-group synchronizer: comma acquisition FSM, bad/good
// hysteresis counters, saturating loss-of-sync counter and SUDI register.
module pcs_sync_lane
  import pcs_sync_pkg::*;
#(
  parameter int unsigned ACQ_COMMAS = 3,
  parameter int unsigned LOSS_BAD   = 4,
  parameter int unsigned GOOD_RUN   = 3,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_power_on,
  input  logic [9:0]       i_pudi,
  output logic [10:0]      o_sudi,
  output logic             o_sync_status,
  output logic [CNT_W-1:0] o_loss_cnt
);

  localparam int unsigned AcqW  = $clog2(ACQ_COMMAS + 1);
  localparam int unsigned BadW  = $clog2(LOSS_BAD + 1);
  localparam int unsigned GoodW = $clog2(GOOD_RUN + 1);

  sync_state_e      r_state, w_state_d;
  logic [AcqW-1:0]  r_acq, w_acq_d, w_acq_inc;
  logic [BadW-1:0]  r_bad, w_bad_d, w_bad_inc;
  logic [GoodW-1:0] r_good, w_good_d, w_good_inc;
  logic             r_rx_even, w_rx_even_d;
  logic [10:0]      r_sudi;
  logic             r_status;
  logic [CNT_W-1:0] r_loss_cnt;
  logic             w_loss_inc;

  logic w_comma, w_invalid, w_data, w_cgbad;

  assign w_comma    = is_comma(i_pudi);
  assign w_invalid  = is_invalid(i_pudi);
  assign w_data     = !w_comma && !w_invalid;
  assign w_cgbad    = w_invalid || (w_comma && r_rx_even);
  assign w_acq_inc  = r_acq + AcqW'(1);
  assign w_bad_inc  = r_bad + BadW'(1);
  assign w_good_inc = r_good + GoodW'(1);

  always_comb begin
    w_state_d   = r_state;
    w_acq_d     = r_acq;
    w_bad_d     = r_bad;
    w_good_d    = r_good;
    w_rx_even_d = ~r_rx_even;
    w_loss_inc  = 1'b0;
    unique case (r_state)
      StLossOfSync: begin
        if (i_power_on && w_comma) begin
          w_rx_even_d = 1'b1;
          w_acq_d     = AcqW'(1);
          w_state_d   = StCommaDetect;
        end
      end
      StCommaDetect: begin
        w_state_d = w_data ? StAcquireSync : StLossOfSync;
      end
      StAcquireSync: begin
        if (w_comma && !r_rx_even) begin
          w_rx_even_d = 1'b1;
          if (w_acq_inc == AcqW'(ACQ_COMMAS)) begin
            w_bad_d   = '0;
            w_good_d  = '0;
            w_state_d = StSyncAcquired;
          end else begin
            w_acq_d   = w_acq_inc;
            w_state_d = StCommaDetect;
          end
        end else if (w_cgbad) begin
          w_state_d = StLossOfSync;
        end
      end
      StSyncAcquired: begin
        if (w_cgbad) begin
          w_good_d = '0;
          w_bad_d  = w_bad_inc;
          if (w_bad_inc == BadW'(LOSS_BAD)) begin
            w_state_d  = StLossOfSync;
            w_loss_inc = 1'b1;
          end
        end else if (r_bad != '0) begin
          // A full run of good groups forgives one bad group.
          if (w_good_inc == GoodW'(GOOD_RUN)) begin
            w_bad_d  = r_bad - BadW'(1);
            w_good_d = '0;
          end else begin
            w_good_d = w_good_inc;
          end
        end else begin
          w_good_d = '0;
        end
      end
      default: w_state_d = StLossOfSync;
    endcase
    if (!i_power_on) begin
      w_state_d   = StLossOfSync;
      w_acq_d     = '0;
      w_bad_d     = '0;
      w_good_d    = '0;
      w_rx_even_d = ~r_rx_even;
      w_loss_inc  = (r_state == StSyncAcquired);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StLossOfSync;
      r_acq      <= '0;
      r_bad      <= '0;
      r_good     <= '0;
      r_rx_even  <= 1'b0;
      r_sudi     <= '0;
      r_status   <= 1'b0;
      r_loss_cnt <= '0;
    end else begin
      r_state   <= w_state_d;
      r_acq     <= w_acq_d;
      r_bad     <= w_bad_d;
      r_good    <= w_good_d;
      r_rx_even <= w_rx_even_d;
      r_sudi    <= {w_rx_even_d, i_pudi};
      r_status  <= (w_state_d == StSyncAcquired);
      if (w_loss_inc && (r_loss_cnt != '1)) begin
        r_loss_cnt <= r_loss_cnt + CNT_W'(1);
      end
    end
  end

  assign o_sudi        = r_sudi;
  assign o_sync_status = r_status;
  assign o_loss_cnt    = r_loss_cnt;

endmodule

// File: rtl/pcs_sync_multi.sv
// N-lane PCS receive code-group synchronizer: independent per-lane
// synchronizers plus a registered all-lanes-synced flag.
module pcs_sync_multi
  import pcs_sync_pkg::*;
#(
  parameter int unsigned NUM_LANES  = 1,
  parameter int unsigned ACQ_COMMAS = 3,
  parameter int unsigned LOSS_BAD   = 4,
  parameter int unsigned GOOD_RUN   = 3,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                       Clk,
  input  logic                       mr_main_reset,
  input  logic                       power_on,
  input  logic [10*NUM_LANES-1:0]    PUDI,
  output logic [11*NUM_LANES-1:0]    SUDI,
  output logic [NUM_LANES-1:0]       code_sync_status,
  output logic                       all_sync,
  output logic [CNT_W*NUM_LANES-1:0] sync_loss_cnt
);

  logic r_all_sync;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    pcs_sync_lane #(
      .ACQ_COMMAS (ACQ_COMMAS),
      .LOSS_BAD   (LOSS_BAD),
      .GOOD_RUN   (GOOD_RUN),
      .CNT_W      (CNT_W)
    ) u_lane (
      .i_clk         (Clk),
      .i_rst_n       (mr_main_reset),
      .i_power_on    (power_on),
      .i_pudi        (PUDI[10*g +: 10]),
      .o_sudi        (SUDI[11*g +: 11]),
      .o_sync_status (code_sync_status[g]),
      .o_loss_cnt    (sync_loss_cnt[CNT_W*g +: CNT_W])
    );
  end

  always_ff @(posedge Clk or negedge mr_main_reset) begin
    if (!mr_main_reset) begin
      r_all_sync <= 1'b0;
    end else begin
      r_all_sync <= &code_sync_status;
    end
  end

  assign all_sync = r_all_sync;

endmodule
